// File: rtl/mem_bus2_arbiter.sv
// ============================================================================
//  Module   : mem_bus2_arbiter
//  Purpose  : Shares the memory controller's single bus-2 port between NREQ
//             line-transfer requesters. Round-robin grant, then one full line
//             transaction per grant: command, data beats, response.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1            clock, rising edge
//    rst          in   1            asynchronous active-high reset
//    i_req        in   NREQ         request valid per requester
//    i_req_cmd    in   2*NREQ       per-requester command (2=READ, 3=WRITE)
//    i_req_addr   in   ADDR_W*NREQ  per-requester line address
//    i_req_wdata  in   DATA_W*NREQ  per-requester write word (taken on WBEAT)
//    o_gnt        out  NREQ         one-hot grant for the whole transaction
//    o_wbeat      out  NREQ         winner's write word consumed this cycle
//    o_rvalid     out  NREQ         o_rdata valid for the winner this cycle
//    o_rdata      out  DATA_W       read beat forwarded from memory
//    o_done       out  NREQ         one-cycle completion pulse
//    o_err        out  NREQ         one-cycle timeout pulse
//    o_m_cmd      out  2            bus-2 command (0=NOP, 2=READ, 3=WRITE)
//    o_m_addr     out  ADDR_W       bus-2 address, 0 while NOP
//    o_m_wdata    out  DATA_W       bus-2 write data, 0 while NOP
//    i_m_resp     in   1            memory response strobe
//    i_m_rdata    in   DATA_W       memory read data, valid with i_m_resp
// ============================================================================
`default_nettype none

module mem_bus2_arbiter #(
    parameter int NREQ      = 2,
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          i_req,
    input  logic [2*NREQ-1:0]        i_req_cmd,
    input  logic [ADDR_W*NREQ-1:0]   i_req_addr,
    input  logic [DATA_W*NREQ-1:0]   i_req_wdata,
    output logic [NREQ-1:0]          o_gnt,
    output logic [NREQ-1:0]          o_wbeat,
    output logic [NREQ-1:0]          o_rvalid,
    output logic [DATA_W-1:0]        o_rdata,
    output logic [NREQ-1:0]          o_done,
    output logic [NREQ-1:0]          o_err,
    output logic [1:0]               o_m_cmd,
    output logic [ADDR_W-1:0]        o_m_addr,
    output logic [DATA_W-1:0]        o_m_wdata,
    input  logic                     i_m_resp,
    input  logic [DATA_W-1:0]        i_m_rdata
);

    localparam int c_PTR_W  = $clog2(NREQ);
    localparam int c_BEAT_W = $clog2(BURST_LEN) + 1;
    localparam int c_TCNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_CMD_NOP   = 2'd0;
    localparam logic [1:0] c_CMD_READ  = 2'd2;
    localparam logic [1:0] c_CMD_WRITE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WBURST = 3'd2,
        S_WAIT   = 3'd3,
        S_RBURST = 3'd4,
        S_FINISH = 3'd5,
        S_ABORT  = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic [c_PTR_W-1:0]     r_ptr;
    logic [c_PTR_W-1:0]     r_win;
    logic [1:0]             r_cmd;
    logic [ADDR_W-1:0]      r_addr;
    logic [c_BEAT_W-1:0]    r_beat;
    logic [c_TCNT_W-1:0]    r_tcnt;

    logic [NREQ-1:0]        r_gnt;
    logic [NREQ-1:0]        r_wbeat;
    logic [NREQ-1:0]        r_rvalid;
    logic [DATA_W-1:0]      r_rdata;
    logic [NREQ-1:0]        r_done;
    logic [NREQ-1:0]        r_err;
    logic [1:0]             r_m_cmd;
    logic [ADDR_W-1:0]      r_m_addr;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                   w_found;
    logic [c_PTR_W-1:0]     w_pick;
    int                     w_idx;

    logic [c_PTR_W-1:0]     w_sel;
    logic [1:0]             w_sel_cmd;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [NREQ-1:0]        w_sel_oh;

    state_t                 w_state_nxt;
    logic [c_BEAT_W-1:0]    w_beat_nxt;
    logic [c_TCNT_W-1:0]    w_tcnt_nxt;
    logic                   w_rbeat;

    logic [NREQ-1:0]        w_gnt_nxt;
    logic [NREQ-1:0]        w_wbeat_nxt;
    logic [NREQ-1:0]        w_rvalid_nxt;
    logic [NREQ-1:0]        w_done_nxt;
    logic [NREQ-1:0]        w_err_nxt;
    logic [1:0]             w_m_cmd_nxt;
    logic [ADDR_W-1:0]      w_m_addr_nxt;

    // ------------------------------------------------------------------
    // Round-robin scan: first requester at or after the pointer (with wrap)
    // that holds REQ with a legal command. Bit 1 of the command marks the
    // legal encodings (2 and 3); 0 and 1 are never eligible.
    // ------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && i_req[w_idx] && i_req_cmd[2*w_idx+1]) begin
                w_found = 1'b1;
                w_pick  = c_PTR_W'(w_idx);
            end
        end
    end

    // In IDLE the registered outputs for ISSUE must be built from the
    // winner being picked right now; afterwards from the latched winner.
    assign w_sel      = (r_state == S_IDLE) ? w_pick : r_win;
    assign w_sel_cmd  = (r_state == S_IDLE) ? i_req_cmd[2*int'(w_pick) +: 2] : r_cmd;
    assign w_sel_addr = (r_state == S_IDLE) ? i_req_addr[ADDR_W*int'(w_pick) +: ADDR_W]
                                            : r_addr;
    assign w_sel_oh   = NREQ'(1) << w_sel;

    // ------------------------------------------------------------------
    // Next-state, beat and timeout counters
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_tcnt_nxt  = r_tcnt;
        w_rbeat     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_ISSUE;
                    w_beat_nxt  = '0;
                    w_tcnt_nxt  = '0;
                end
            end

            S_ISSUE: begin
                w_tcnt_nxt = '0;
                if (r_cmd == c_CMD_WRITE) begin
                    // Word 0 goes out with the command itself.
                    w_state_nxt = S_WBURST;
                    w_beat_nxt  = c_BEAT_W'(1);
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end

            S_WBURST: begin
                w_beat_nxt = r_beat + 1'b1;
                if (r_beat == c_BEAT_W'(BURST_LEN - 1)) begin
                    w_state_nxt = S_WAIT;
                    w_tcnt_nxt  = '0;
                end
            end

            S_WAIT: begin
                if (i_m_resp) begin
                    w_tcnt_nxt = '0;
                    if (r_cmd == c_CMD_WRITE) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_rbeat     = 1'b1;
                        w_state_nxt = S_RBURST;
                        w_beat_nxt  = c_BEAT_W'(1);
                    end
                end else if (r_tcnt == c_TCNT_W'(TIMEOUT - 1)) begin
                    w_state_nxt = S_ABORT;
                end else if (r_tcnt != '1) begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end

            S_RBURST: begin
                if (i_m_resp) begin
                    w_rbeat    = 1'b1;
                    w_tcnt_nxt = '0;
                    w_beat_nxt = r_beat + 1'b1;
                    if (r_beat + 1'b1 == c_BEAT_W'(BURST_LEN)) begin
                        w_state_nxt = S_FINISH;
                    end
                end else if (r_tcnt == c_TCNT_W'(TIMEOUT - 1)) begin
                    // A stalled burst uses the same response deadline.
                    w_state_nxt = S_ABORT;
                end else if (r_tcnt != '1) begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end

            S_FINISH: w_state_nxt = S_IDLE;
            S_ABORT:  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output values for the state being entered; registered below so every
    // output is aligned with the state it belongs to.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt_nxt    = '0;
        w_wbeat_nxt  = '0;
        w_done_nxt   = '0;
        w_err_nxt    = '0;
        w_m_cmd_nxt  = c_CMD_NOP;
        w_m_addr_nxt = '0;
        w_rvalid_nxt = '0;

        case (w_state_nxt)
            S_ISSUE: begin
                w_gnt_nxt   = w_sel_oh;
                w_m_cmd_nxt = w_sel_cmd;
                if (w_sel_cmd == c_CMD_WRITE) begin
                    w_wbeat_nxt = w_sel_oh;
                end
            end
            S_WBURST: begin
                w_gnt_nxt   = w_sel_oh;
                w_m_cmd_nxt = c_CMD_WRITE;
                w_wbeat_nxt = w_sel_oh;
            end
            S_WAIT, S_RBURST: w_gnt_nxt  = w_sel_oh;
            S_FINISH:         w_done_nxt = w_sel_oh;
            S_ABORT:          w_err_nxt  = w_sel_oh;
            default: ;
        endcase

        if (w_m_cmd_nxt != c_CMD_NOP) begin
            w_m_addr_nxt = w_sel_addr;
        end
        if (w_rbeat) begin
            w_rvalid_nxt = w_sel_oh;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_win    <= '0;
            r_cmd    <= c_CMD_NOP;
            r_addr   <= '0;
            r_beat   <= '0;
            r_tcnt   <= '0;
            r_gnt    <= '0;
            r_wbeat  <= '0;
            r_rvalid <= '0;
            r_rdata  <= '0;
            r_done   <= '0;
            r_err    <= '0;
            r_m_cmd  <= c_CMD_NOP;
            r_m_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_tcnt  <= w_tcnt_nxt;

            if (r_state == S_IDLE && w_found) begin
                r_win  <= w_pick;
                r_cmd  <= w_sel_cmd;
                r_addr <= w_sel_addr;
                r_ptr  <= (w_pick == c_PTR_W'(NREQ - 1)) ? '0 : w_pick + 1'b1;
            end

            r_gnt    <= w_gnt_nxt;
            r_wbeat  <= w_wbeat_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_m_cmd  <= w_m_cmd_nxt;
            r_m_addr <= w_m_addr_nxt;

            // Read data holds its last beat between RVALID pulses.
            if (w_rbeat) begin
                r_rdata <= i_m_rdata;
            end
        end
    end

    assign o_gnt    = r_gnt;
    assign o_wbeat  = r_wbeat;
    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;
    assign o_done   = r_done;
    assign o_err    = r_err;
    assign o_m_cmd  = r_m_cmd;
    assign o_m_addr = r_m_addr;

    // Write data passes straight through from the winner: WBEAT and the
    // word it consumes sit in the same cycle, and the requester steps to
    // its next word on the edge that closes that cycle.
    assign o_m_wdata = (r_m_cmd == c_CMD_WRITE) ? i_req_wdata[DATA_W*int'(r_win) +: DATA_W]
                                                : '0;

endmodule

`default_nettype wire

// File: doc/mem_bus2_arbiter.md
Name: mem_bus2_arbiter

Overview:
- Shares the single bus-2 port of the memory controller between NREQ line-transfer requesters, such as the cache and a dump/DMA engine.
- Grants requesters round-robin and sequences one full line transaction per grant: command, data beats, then the response.
- Forwards write beats from the winner to memory and read beats from memory back to the winner.
- Detects memory timeouts and reports completion per requester.

Parameters:
- NREQ, 2, number of requesters (2..4)
- ADDR_W, 15, line address width
- DATA_W, 16, bus-2 data word width
- BURST_LEN, 8, data beats per line transaction (power of 2, >=2)
- TIMEOUT, 255, maximum cycles to wait for the memory response before aborting

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- REQ  in  NREQ  request valid per requester; held until DONE or ERR
- REQ_CMD  in  2*NREQ  per-requester command: 2=READ_LINE, 3=WRITE_LINE (0/1 illegal, ignored)
- REQ_ADDR  in  ADDR_W*NREQ  per-requester line address
- REQ_WDATA  in  DATA_W*NREQ  per-requester write word, sampled on WBEAT
- GNT  out  NREQ  one-hot grant, high for the whole transaction
- WBEAT  out  NREQ  one-hot pulse: the winner's REQ_WDATA is consumed this cycle; winner advances to the next word
- RVALID  out  NREQ  one-hot: RDATA is valid for the winner this cycle
- RDATA  out  DATA_W  read beat forwarded from memory
- DONE  out  NREQ  one-cycle completion pulse
- ERR  out  NREQ  one-cycle timeout pulse
- M_CMD  out  2  bus-2 command to memory: 0=NOP, 2=READ_LINE, 3=WRITE_LINE
- M_ADDR  out  ADDR_W  bus-2 address, valid while M_CMD != NOP
- M_WDATA  out  DATA_W  bus-2 write data
- M_RESP  in  1  memory drives C2_RESPONSE this cycle
- M_RDATA  in  DATA_W  memory read data, valid with M_RESP

Behaviour:

Reset and arbitration:
- While RESET is high, all outputs are 0, the state is IDLE, the round-robin pointer is 0, and the beat and timeout counters are 0.
- RESET asserted mid-transaction aborts it immediately; no DONE or ERR is issued and requesters must re-request.
- Arbitration happens only in IDLE.
- The winner is the first requester with REQ high and a legal REQ_CMD, scanning from the pointer upward with wrap.
- After a grant, the pointer moves to winner+1 mod NREQ.
- A REQ with an illegal command is skipped and never granted.

State machine (registered outputs, one state per cycle unless noted):
- IDLE: when a winner exists, latch its index, command and address, then go to ISSUE. GNT rises in the same edge as entering ISSUE.
- ISSUE, 1 cycle: M_CMD and M_ADDR are driven.
  - WRITE: also drive M_WDATA = word 0 and pulse WBEAT; go to WBURST with beat=1.
  - READ: go to WAIT.
- WBURST: drive M_CMD = WRITE_LINE, M_WDATA = winner's word and WBEAT each cycle, beat++. After beat BURST_LEN-1, M_CMD returns to NOP; go to WAIT.
  - Total write bus occupancy is BURST_LEN consecutive cycles including ISSUE.
- WAIT: M_CMD = NOP and the timeout counter increments.
  - On M_RESP: for a WRITE go to FINISH; for a READ forward beat 0 (RVALID and RDATA in the next cycle) and go to RBURST with beat=1.
  - When the counter reaches TIMEOUT with no M_RESP: go to ABORT.
- RBURST: each M_RESP cycle forwards one beat, beat++. When beat reaches BURST_LEN, go to FINISH.
  - A missing M_RESP mid-burst stalls with no RVALID and counts toward TIMEOUT (counter reset on each received beat).
- FINISH, 1 cycle: DONE[winner] pulses, GNT drops, go to IDLE.
- ABORT, 1 cycle: ERR[winner] pulses, GNT drops, go to IDLE.

Timing and boundary rules:
- The earliest re-grant is the cycle after FINISH; IDLE lasts at least 1 cycle between transactions.
- M_RESP seen while not in WAIT or RBURST is ignored.
- Extra M_RESP after the last read beat is ignored.
- The winner dropping REQ mid-transaction does not abort; the transaction completes.
- Beat counter width is clog2(BURST_LEN)+1; the timeout counter saturates and never wraps.
- RDATA holds its last value when RVALID is low. M_ADDR and M_WDATA are 0 when M_CMD is NOP.

Test Plan:
- Single read: REQ[0], cmd 2, addr 0x1A2. Expect:
  - 1 cycle of M_CMD=2, M_ADDR=0x1A2.
  - Memory responds 8 beats 0x10..0x17, giving RVALID[0] on 8 cycles with RDATA 0x10..0x17.
  - DONE[0] once, then GNT=0.
- Single write: REQ[1], cmd 3, addr 0x005, words 0xA0..0xA7. Expect:
  - M_CMD=3 on 8 consecutive cycles, M_WDATA 0xA0..0xA7, with 8 WBEAT[1] pulses.
  - M_RESP one cycle later gives DONE[1].
- Contention: REQ[0] and REQ[1] held continuously with 4 transactions each. Expect:
  - Grant order 0,1,0,1,…
  - Never two GNT bits high together.
- Timeout: read with no M_RESP. Expect ERR[0] exactly 255 cycles after WAIT entry, no DONE, and return to IDLE.
- Reset mid-WBURST after beat 3: expect all outputs 0 immediately, M_CMD=0, pointer 0, and a re-request is granted normally.
- Illegal command: REQ[0] with cmd 1 and REQ[1] with cmd 2. Expect only requester 1 granted; requester 0 is never granted.
